// File: rtl/ppu_pkg.sv
// Shared fetch-path types: FSM state encoding and big-endian byte-lane mapping.
// Lane 0 carries the most significant byte of an instruction word.
package ppu_pkg;

    localparam int BYTES_PER_INSTR = 4;
    localparam int LANE_W          = 8;
    localparam int INSTR_W         = BYTES_PER_INSTR * LANE_W;

    // F0..F3 encode the lane being fetched in their two low bits
    typedef enum logic [2:0] {
        F0   = 3'd0,
        F1   = 3'd1,
        F2   = 3'd2,
        F3   = 3'd3,
        HOLD = 3'd4
    } fetch_state_t;

    localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_INSTR - 1);

    function automatic int lane_lsb(input int lane);
        return (BYTES_PER_INSTR - 1 - lane) * LANE_W;
    endfunction

endpackage

// File: rtl/instr_fetch_seq_if.sv
// Fetch-stage bus: byte RAM read port, redirect/stall inputs and the IF/ID valid/ready output.
// master = fetch sequencer side, slave = RAM / hazard unit / IF-ID side.
interface instr_fetch_seq_if #(
    parameter int ADDR_W = 8
);
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              stall;
    logic              take_branch;
    logic [ADDR_W-1:0] branch_target;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        output mem_en, mem_addr, instr, instr_pc, instr_valid,
        input  mem_data, stall, take_branch, branch_target, instr_ready
    );

    modport slave (
        input  mem_en, mem_addr, instr, instr_pc, instr_valid,
        output mem_data, stall, take_branch, branch_target, instr_ready
    );
endinterface

// File: rtl/fetch_word_assembler.sv
// Four byte-lane registers with lane-select write and synchronous clear; word is big-endian.
// Write lands on the next edge; no handshake, the owner decides when lanes are written.
module fetch_word_assembler
    import ppu_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               wr_en,
    input  logic [1:0]         wr_lane,
    input  logic [LANE_W-1:0]  wr_byte,
    output logic [INSTR_W-1:0] word
);

    logic [BYTES_PER_INSTR-1:0][LANE_W-1:0] lane_q, lane_d;

    always_comb begin
        lane_d = lane_q;
        if (clr) begin
            lane_d = '0;
        end else if (wr_en) begin
            lane_d[wr_lane] = wr_byte;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_q <= '0;
        end else begin
            lane_q <= lane_d;
        end
    end

    always_comb begin
        word = '0;
        for (int k = 0; k < BYTES_PER_INSTR; k++) begin
            word[lane_lsb(k) +: LANE_W] = lane_q[k];
        end
    end

endmodule

// File: rtl/instr_fetch_seq.sv
// Byte-serial instruction fetch: four RAM reads per word, word held on a valid/ready output.
// Valid 4 cycles after entering F0 (plus stall cycles); holds word until accepted; redirect beats stall.
module instr_fetch_seq
    import ppu_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    instr_fetch_seq_if.master  bus
);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;

    logic [ADDR_W-1:0]  byte_addr;
    logic [INSTR_W-1:0] asm_word;
    logic [1:0]         lane_sel;
    logic               fetching;
    logic               capture;
    logic               accept;
    logic               lane_clr;

    always_comb begin
        fetching  = (state_q != HOLD);
        lane_sel  = state_q[1:0];
        byte_addr = pc_q + ADDR_W'(lane_sel);

        // Gating with reset_n keeps the RAM idle while reset is held, even though state is F0
        bus.mem_en   = reset_n & fetching & ~bus.stall;
        bus.mem_addr = bus.mem_en ? byte_addr : mem_addr_q;
        mem_addr_d   = bus.mem_addr;

        capture = bus.mem_en & ~bus.take_branch;
        accept  = valid_q & bus.instr_ready;

        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        lane_clr   = 1'b0;

        if (bus.take_branch) begin
            // A simultaneous accept has already handed the word over; only the pc+4 step is lost
            state_d  = F0;
            pc_d     = bus.branch_target & ~ADDR_W'(BYTES_PER_INSTR - 1);
            valid_d  = 1'b0;
            lane_clr = 1'b1;
        end else if (state_q == HOLD) begin
            if (accept) begin
                state_d = F0;
                pc_d    = pc_q + ADDR_W'(BYTES_PER_INSTR);
                valid_d = 1'b0;
            end
        end else if (capture) begin
            if (lane_sel == LAST_LANE) begin
                state_d    = HOLD;
                valid_d    = 1'b1;
                instr_pc_d = pc_q;
                instr_d    = asm_word;
                instr_d[lane_lsb(BYTES_PER_INSTR - 1) +: LANE_W] = bus.mem_data;
            end else begin
                state_d = fetch_state_t'(state_q + 3'd1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= F0;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = valid_q;

    fetch_word_assembler u_asm (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (lane_clr),
        .wr_en   (capture),
        .wr_lane (lane_sel),
        .wr_byte (bus.mem_data),
        .word    (asm_word)
    );

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: dut_a starts at pc 0x00, dut_b at 0xFC to exercise address wrap.
// Accepted words are scored against a queue filled when the fetch that produces them is launched.
module tb_instr_fetch_seq;

    logic clk = 1'b0;
    logic rst_a_n;
    logic rst_b_n;
    always #5 clk = ~clk;

    instr_fetch_seq_if #(.ADDR_W(8)) ifa ();
    instr_fetch_seq_if #(.ADDR_W(8)) ifb ();

    logic [7:0] ram [256];
    assign ifa.mem_data = ram[ifa.mem_addr];
    assign ifb.mem_data = ram[ifb.mem_addr];

    instr_fetch_seq #(.ADDR_W(8), .RESET_PC(8'h00)) dut_a (.clk(clk), .reset_n(rst_a_n), .bus(ifa));
    instr_fetch_seq #(.ADDR_W(8), .RESET_PC(8'hFC)) dut_b (.clk(clk), .reset_n(rst_b_n), .bus(ifb));

    typedef struct packed {
        logic [31:0] instr;
        logic [7:0]  pc;
    } exp_t;

    typedef struct {
        logic [7:0]  target;
        int          stall_at;
        int          stall_len;
        int          ready_wait;
        logic [31:0] exp_instr;
        logic [7:0]  exp_pc;
        logic [31:0] exp_next;
    } vec_t;

    exp_t        sb [$];
    vec_t        vecs [5];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  hold_pc;
    logic [31:0] hold_instr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int limit, output int cyc);
        cyc = 0;
        while (ifa.instr_valid !== 1'b1 && cyc < limit) begin
            tick();
            cyc++;
        end
    endtask

    // Scoreboard: every accept on dut_a must match the oldest expected word
    always @(negedge clk) begin
        if (ifa.instr_valid === 1'b1 && ifa.instr_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL sb_accept: got %h @%h expected no accept", ifa.instr, ifa.instr_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_instr", ifa.instr, e.instr);
                chk("sb_pc", 32'(ifa.instr_pc), 32'(e.pc));
            end
        end
    end

    initial begin
        #60000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int c;
        logic [7:0] frozen;
        logic [7:0] npc;

        for (int i = 0; i < 256; i++) ram[i] = 8'(i);
        ram[0] = 8'hE3; ram[1] = 8'hA0; ram[2] = 8'h10; ram[3] = 8'h05;
        ram[4] = 8'hE2; ram[5] = 8'h81; ram[6] = 8'h20; ram[7] = 8'h01;

        vecs[0] = '{8'h0B, 0, 0, 6, 32'h08090A0B, 8'h08, 32'h0C0D0E0F};
        vecs[1] = '{8'h13, 2, 3, 1, 32'h10111213, 8'h10, 32'h14151617};
        vecs[2] = '{8'hFE, 0, 1, 0, 32'hFCFDFEFF, 8'hFC, 32'hE3A01005};
        vecs[3] = '{8'h01, 3, 2, 2, 32'hE3A01005, 8'h00, 32'hE2812001};
        vecs[4] = '{8'h42, 1, 1, 0, 32'h40414243, 8'h40, 32'h44454647};

        rst_a_n = 1'b0; rst_b_n = 1'b0;
        ifa.stall = 1'b0; ifa.take_branch = 1'b0; ifa.branch_target = 8'h00; ifa.instr_ready = 1'b0;
        ifb.stall = 1'b0; ifb.take_branch = 1'b0; ifb.branch_target = 8'h00; ifb.instr_ready = 1'b0;
        repeat (2) tick();

        chk("rst_a_valid", 32'(ifa.instr_valid), 32'd0);
        chk("rst_a_mem_en", 32'(ifa.mem_en), 32'd0);
        chk("rst_a_mem_addr", 32'(ifa.mem_addr), 32'd0);
        chk("rst_a_instr", ifa.instr, 32'd0);
        chk("rst_a_instr_pc", 32'(ifa.instr_pc), 32'd0);
        chk("rst_b_valid", 32'(ifb.instr_valid), 32'd0);
        chk("rst_b_mem_en", 32'(ifb.mem_en), 32'd0);
        chk("rst_b_mem_addr", 32'(ifb.mem_addr), 32'd0);

        // Basic stream: two words back-to-back with ready held high
        sb.push_back('{32'hE3A01005, 8'h00});
        sb.push_back('{32'hE2812001, 8'h04});
        rst_a_n = 1'b1; rst_b_n = 1'b1; ifa.instr_ready = 1'b1;
        #1;
        chk("rel_a_mem_en", 32'(ifa.mem_en), 32'd1);
        chk("rel_a_mem_addr", 32'(ifa.mem_addr), 32'h00);
        chk("rel_b_mem_addr", 32'(ifb.mem_addr), 32'hFC);

        fork
            begin : a_side
                int ca;
                wait_valid(20, ca);
                chk("first_latency", 32'(ca), 32'd4);
                chk("first_instr", ifa.instr, 32'hE3A01005);
                tick();
                chk("accept_clears_valid", 32'(ifa.instr_valid), 32'd0);
                chk("next_addr_pc4", 32'(ifa.mem_addr), 32'h04);
                wait_valid(20, ca);
                chk("throughput", 32'(ca + 1), 32'd5);
                tick();
                ifa.instr_ready = 1'b0;
                wait_valid(20, ca);
                chk("third_latency", 32'(ca), 32'd4);
                chk("third_instr", ifa.instr, 32'h08090A0B);
                chk("third_pc", 32'(ifa.instr_pc), 32'h08);
            end
            begin : b_side
                int cb;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("b_mem_en", 32'(ifb.mem_en), 32'd1);
                    chk("b_mem_addr", 32'(ifb.mem_addr), 32'(8'hFC + 8'(k)));
                    tick();
                end
                chk("b_valid", 32'(ifb.instr_valid), 32'd1);
                chk("b_instr", ifb.instr, 32'hFCFDFEFF);
                chk("b_pc", 32'(ifb.instr_pc), 32'hFC);
                ifb.instr_ready = 1'b1;
                tick();
                ifb.instr_ready = 1'b0;
                chk("b_wrap_addr", 32'(ifb.mem_addr), 32'h00);
                chk("b_wrap_en", 32'(ifb.mem_en), 32'd1);
                cb = 0;
                while (ifb.instr_valid !== 1'b1 && cb < 10) begin
                    tick();
                    cb++;
                end
                chk("b_wrap_latency", 32'(cb), 32'd4);
                chk("b_wrap_instr", ifb.instr, 32'hE3A01005);
                chk("b_wrap_pc", 32'(ifb.instr_pc), 32'h00);
            end
        join
        hold_pc    = 8'h08;
        hold_instr = 32'h08090A0B;

        // Table: redirect from HOLD (held word dropped), optional stall, ready backpressure, accept
        for (int i = 0; i < 5; i++) begin
            vec_t v;
            v = vecs[i];
            frozen = (v.stall_at == 0) ? hold_pc + 8'd3 : v.exp_pc + 8'(v.stall_at - 1);
            npc    = v.exp_pc + 8'd4;
            sb.push_back('{v.exp_instr, v.exp_pc});
            ifa.take_branch   = 1'b1;
            ifa.branch_target = v.target;
            tick();
            ifa.take_branch = 1'b0;
            chk("br_drop_valid", 32'(ifa.instr_valid), 32'd0);
            chk("br_addr", 32'(ifa.mem_addr), 32'(v.exp_pc));
            c = 0;
            while (ifa.instr_valid !== 1'b1 && c < 30) begin
                ifa.stall = (c >= v.stall_at && c < v.stall_at + v.stall_len);
                @(negedge clk);
                if (ifa.stall) begin
                    chk("stall_mem_en", 32'(ifa.mem_en), 32'd0);
                    chk("stall_addr_frozen", 32'(ifa.mem_addr), 32'(frozen));
                end else if (v.stall_len > 0 && c == v.stall_at + v.stall_len) begin
                    chk("resume_en", 32'(ifa.mem_en), 32'd1);
                    chk("resume_addr", 32'(ifa.mem_addr), 32'(v.exp_pc + 8'(v.stall_at)));
                end
                tick();
                c++;
            end
            ifa.stall = 1'b0;
            chk("vec_latency", 32'(c), 32'(4 + v.stall_len));
            chk("vec_instr", ifa.instr, v.exp_instr);
            chk("vec_pc", 32'(ifa.instr_pc), 32'(v.exp_pc));
            for (int w = 0; w < v.ready_wait; w++) begin
                ifa.stall = 1'b1;
                @(negedge clk);
                chk("hold_valid", 32'(ifa.instr_valid), 32'd1);
                chk("hold_mem_en", 32'(ifa.mem_en), 32'd0);
                chk("hold_instr", ifa.instr, v.exp_instr);
                chk("hold_pc", 32'(ifa.instr_pc), 32'(v.exp_pc));
                tick();
            end
            ifa.stall = 1'b0;
            ifa.instr_ready = 1'b1;
            tick();
            ifa.instr_ready = 1'b0;
            chk("acc_valid", 32'(ifa.instr_valid), 32'd0);
            chk("acc_next_addr", 32'(ifa.mem_addr), 32'(npc));
            wait_valid(20, c);
            chk("next_latency", 32'(c), 32'd4);
            chk("next_instr", ifa.instr, v.exp_next);
            chk("next_pc", 32'(ifa.instr_pc), 32'(npc));
            hold_pc    = npc;
            hold_instr = v.exp_next;
        end

        // Redirect during F1: partial word discarded, refetch from aligned target
        sb.push_back('{hold_instr, hold_pc});
        ifa.instr_ready = 1'b1;
        tick();
        ifa.instr_ready = 1'b0;
        chk("f1_start_addr", 32'(ifa.mem_addr), 32'(hold_pc + 8'd4));
        tick();
        ifa.take_branch   = 1'b1;
        ifa.branch_target = 8'h0B;
        tick();
        ifa.take_branch = 1'b0;
        chk("f1_br_addr", 32'(ifa.mem_addr), 32'h08);
        chk("f1_br_valid", 32'(ifa.instr_valid), 32'd0);
        wait_valid(20, c);
        chk("f1_br_latency", 32'(c), 32'd4);
        chk("f1_br_instr", ifa.instr, 32'h08090A0B);
        chk("f1_br_pc", 32'(ifa.instr_pc), 32'h08);

        // Accept and redirect on the same edge: word delivered, pc goes to target
        sb.push_back('{32'h08090A0B, 8'h08});
        ifa.instr_ready   = 1'b1;
        ifa.take_branch   = 1'b1;
        ifa.branch_target = 8'h21;
        tick();
        ifa.instr_ready = 1'b0;
        ifa.take_branch = 1'b0;
        chk("acc_br_valid", 32'(ifa.instr_valid), 32'd0);
        chk("acc_br_addr", 32'(ifa.mem_addr), 32'h20);
        wait_valid(20, c);
        chk("acc_br_latency", 32'(c), 32'd4);
        chk("acc_br_instr", ifa.instr, 32'h20212223);
        chk("acc_br_pc", 32'(ifa.instr_pc), 32'h20);

        // Asynchronous reset in F2: outputs clear at once, restart from RESET_PC
        sb.push_back('{32'h20212223, 8'h20});
        ifa.instr_ready = 1'b1;
        tick();
        ifa.instr_ready = 1'b0;
        tick();
        tick();
        chk("f2_addr", 32'(ifa.mem_addr), 32'h26);
        #2 rst_a_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ifa.instr_valid), 32'd0);
        chk("arst_mem_en", 32'(ifa.mem_en), 32'd0);
        chk("arst_mem_addr", 32'(ifa.mem_addr), 32'd0);
        chk("arst_instr", ifa.instr, 32'd0);
        chk("arst_instr_pc", 32'(ifa.instr_pc), 32'd0);
        @(posedge clk);
        #1 rst_a_n = 1'b1;
        #1;
        chk("rerel_mem_en", 32'(ifa.mem_en), 32'd1);
        chk("rerel_mem_addr", 32'(ifa.mem_addr), 32'h00);
        wait_valid(20, c);
        chk("rerel_latency", 32'(c), 32'd4);
        chk("rerel_instr", ifa.instr, 32'hE3A01005);
        chk("rerel_pc", 32'(ifa.instr_pc), 32'h00);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
